// File: rtl/compacting_lane_fifo_pkg.sv
// compacting_lane_fifo_pkg
// Shared helpers for the compacting lane FIFO:
//   - DEF_* : default configuration of the FIFO
//   - PTR_W, LVL_W, INCNT_W, OUTCNT_W : width helpers for the default configuration
//     (modules built with other parameters derive their own widths the same way)
//   - popcount_lanes : number of set bits in a lane mask (masks up to 64 lanes)
//   - min_u : unsigned minimum, used for the output-count and pop clamps
package compacting_lane_fifo_pkg;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_IN_LANES  = 4;
  localparam int DEF_OUT_LANES = 2;
  localparam int DEF_DEPTH     = 256;

  localparam int PTR_W    = $clog2(DEF_DEPTH);
  localparam int LVL_W    = $clog2(DEF_DEPTH + 1);
  localparam int INCNT_W  = $clog2(DEF_IN_LANES + 1);
  localparam int OUTCNT_W = $clog2(DEF_OUT_LANES + 1);

  function automatic int unsigned popcount_lanes(input logic [63:0] mask);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'd0, mask[i]};
    end
    return n;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/compacting_lane_fifo_compactor.sv
// lane_compactor
// Purely combinational packer: moves the kept input lanes down to the low
// output slots, preserving ascending lane order.
//   in_data     : input words, lane 0 oldest
//   in_keep     : per-lane keep mask
//   packed_data : kept words in slots 0..kept-1, zeros above
//   kept        : number of kept lanes
// Each kept lane's destination slot is the number of kept lanes below it
// (exclusive prefix sum); each slot then selects the one lane aimed at it.
module lane_compactor
  import compacting_lane_fifo_pkg::*;
#(
  parameter int  BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int  IN_LANES  = DEF_IN_LANES,
  parameter type DATA_TYPE = logic [BIT_WIDTH-1:0]
) (
  input  DATA_TYPE                          in_data     [IN_LANES],
  input  logic [IN_LANES-1:0]               in_keep,
  output DATA_TYPE                          packed_data [IN_LANES],
  output logic [$clog2(IN_LANES+1)-1:0]     kept
);

  localparam int CW = $clog2(IN_LANES + 1);

  logic [CW-1:0] pos [IN_LANES];

  always_comb begin
    logic [CW-1:0] run;
    run = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      pos[i] = run;
      run    = run + CW'(in_keep[i]);
    end
  end

  assign kept = CW'(popcount_lanes(64'(in_keep)));

  for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_slot
    DATA_TYPE slot;
    always_comb begin
      slot = '0;
      for (int i = 0; i < IN_LANES; i++) begin
        if (in_keep[i] && (pos[i] == CW'(gi))) begin
          slot = in_data[i];
        end
      end
    end
    assign packed_data[gi] = slot;
  end

endmodule

// File: rtl/compacting_lane_fifo.sv
// compacting_lane_fifo
// Multi-lane filtered FIFO: accepts up to IN_LANES words per beat, keeps the
// lanes flagged in in_keep, stores them packed in arrival order and presents
// up to OUT_LANES head words; the consumer pops a variable number per cycle.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_valid       : beat offered
//   in_data/in_keep: input words (lane 0 oldest) and keep mask
//   in_ready       : room for a full beat (independent of in_keep)
//   out_data       : head words, lane 0 oldest, zero above out_count
//   out_count      : number of valid out_data lanes
//   out_take       : words popped this cycle (clamped to out_count)
//   level          : current occupancy
//   stat_kept/stat_dropped/stat_peak : only when COMPACTING_LANE_FIFO_STATS_EN
//                    is defined; saturating word counts and peak level
module compacting_lane_fifo
  import compacting_lane_fifo_pkg::*;
#(
  parameter int  BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int  IN_LANES  = DEF_IN_LANES,
  parameter int  OUT_LANES = DEF_OUT_LANES,
  parameter int  DEPTH     = DEF_DEPTH,
  parameter type DATA_TYPE = logic [BIT_WIDTH-1:0]
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  DATA_TYPE                           in_data  [IN_LANES],
  input  logic [IN_LANES-1:0]                in_keep,
  output logic                               in_ready,
  output DATA_TYPE                           out_data [OUT_LANES],
  output logic [$clog2(OUT_LANES+1)-1:0]     out_count,
  input  logic [$clog2(OUT_LANES+1)-1:0]     out_take,
  output logic [$clog2(DEPTH+1)-1:0]         level
`ifdef COMPACTING_LANE_FIFO_STATS_EN
  ,
  output logic [31:0]                        stat_kept,
  output logic [31:0]                        stat_dropped,
  output logic [$clog2(DEPTH+1)-1:0]         stat_peak
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int ICW = $clog2(IN_LANES + 1);
  localparam int OCW = $clog2(OUT_LANES + 1);
  localparam int XW  = LW + 1;

  DATA_TYPE       mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [LW-1:0]  level_reg;
  logic [LW-1:0]  level_next;

  DATA_TYPE       packed_data [IN_LANES];
  logic [ICW-1:0] kept;
  logic           push;
  logic [ICW-1:0] push_n;
  logic [OCW-1:0] pop_n;

  lane_compactor #(
    .BIT_WIDTH (BIT_WIDTH),
    .IN_LANES  (IN_LANES),
    .DATA_TYPE (DATA_TYPE)
  ) u_compactor (
    .in_data     (in_data),
    .in_keep     (in_keep),
    .packed_data (packed_data),
    .kept        (kept)
  );

  // Ready asks for room for a whole beat regardless of how many lanes are
  // kept, so it depends on registered occupancy only.
  assign in_ready  = (level_reg <= LW'(DEPTH - IN_LANES));
  assign push      = in_valid && in_ready;
  assign push_n    = push ? kept : '0;
  assign out_count = OCW'(min_u(32'(level_reg), 32'(OUT_LANES)));
  assign pop_n     = OCW'(min_u(32'(out_take), 32'(out_count)));
  // One spare bit so the intermediate sum cannot wrap before the subtract.
  assign level_next = LW'(XW'(level_reg) + XW'(push_n) - XW'(pop_n));
  assign level     = level_reg;

  for (genvar gi = 0; gi < OUT_LANES; gi++) begin : g_out
    logic [AW-1:0] addr;
    assign addr         = rd_ptr_reg + AW'(gi);
    assign out_data[gi] = (OCW'(gi) < out_count) ? mem[addr] : '0;
  end

  // Storage has no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int k = 0; k < IN_LANES; k++) begin
        if (ICW'(k) < kept) begin
          mem[wr_ptr_reg + AW'(k)] <= packed_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_n);
      level_reg  <= level_next;
    end
  end

`ifdef COMPACTING_LANE_FIFO_STATS_EN
  logic [31:0]   stat_kept_reg;
  logic [31:0]   stat_dropped_reg;
  logic [LW-1:0] stat_peak_reg;
  logic [32:0]   kept_sum;
  logic [32:0]   drop_sum;

  assign kept_sum = {1'b0, stat_kept_reg} + 33'(push_n);
  assign drop_sum = {1'b0, stat_dropped_reg} + (push ? (33'(IN_LANES) - 33'(kept)) : 33'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_kept_reg    <= '0;
      stat_dropped_reg <= '0;
      stat_peak_reg    <= '0;
    end else begin
      stat_kept_reg    <= kept_sum[32] ? '1 : kept_sum[31:0];
      stat_dropped_reg <= drop_sum[32] ? '1 : drop_sum[31:0];
      if (level_next > stat_peak_reg) begin
        stat_peak_reg <= level_next;
      end
    end
  end

  assign stat_kept    = stat_kept_reg;
  assign stat_dropped = stat_dropped_reg;
  assign stat_peak    = stat_peak_reg;
`endif

endmodule
